// File: rtl/sdram_frame_pkg.sv
// Shared types and helpers for the triple-buffer SDRAM frame scheduler.
// The optional statistics counters in sdram_frame_sched are enabled by
// defining SDRAM_FRAME_SCHED_STATS_EN.
package sdram_frame_pkg;

    localparam int NUM_BUF = 3;
    localparam int ADDR_W  = 22;

    // Index of one of the three frame regions (values 0..2 only)
    typedef logic [1:0] buf_idx_t;

    typedef enum logic [0:0] {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } sched_state_t;

    // Word address of region idx: base + idx*size (22-bit, no wrap check)
    function automatic logic [ADDR_W-1:0] buf_base(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] size,
        input buf_idx_t          idx
    );
        logic [ADDR_W-1:0] off;
        off = size * {{(ADDR_W-2){1'b0}}, idx};
        return base + off;
    endfunction

    // The region that is neither a nor b (a, b distinct, both in 0..2)
    function automatic buf_idx_t third_buf(input buf_idx_t a, input buf_idx_t b);
        return 2'd3 - a - b;
    endfunction

endpackage

// File: rtl/frame_load_pulse.sv
// Load strobe generator: a start holds load_o high for exactly LOAD_CYCLES
// cycles. A start during an active strobe reloads the counter, so the strobe
// stays continuously high with no extra edge. clr_i forces the strobe low.
module frame_load_pulse #(
    parameter int LOAD_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic start_i,
    output logic load_o
);

    localparam int CW = $clog2(LOAD_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: reload on start, otherwise count down to zero
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (start_i) begin
            count_d = CW'(LOAD_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign load_o = (count_q != '0);

endmodule

// File: rtl/sdram_frame_sched.sv
// Triple-buffer frame scheduler: picks the region the camera writes and the
// region the display reads, promoting only fully written frames.
// Optional feature macro: SDRAM_FRAME_SCHED_STATS_EN (adds drop_cnt and
// repeat_cnt outputs).
//
// Handshake: wr_frame_start / rd_frame_start are single-cycle events with no
// back-pressure; each accepted start produces a LOAD_CYCLES-wide load strobe,
// and the matching address outputs are valid from the first strobe cycle.
module sdram_frame_sched
    import sdram_frame_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR   = 22'd0,
    parameter logic [21:0] FRAME_SIZE  = 22'd307200,
    parameter int          LOAD_CYCLES = 4
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    input  logic        frame_write_done,
    output logic        wr_load,
    output logic [21:0] wr_addr,
    output logic [21:0] wr_max_addr,
    output logic        rd_load,
    output logic [21:0] rd_addr,
    output logic [21:0] rd_max_addr,
    output logic [1:0]  wr_idx,
    output logic [1:0]  rd_idx,
`ifdef SDRAM_FRAME_SCHED_STATS_EN
    output logic [15:0] drop_cnt,
    output logic [15:0] repeat_cnt,
`endif
    output logic        latest_valid
);

    sched_state_t state_q;
    sched_state_t state_d;

    logic run_en;
    logic wr_accept;
    logic rd_accept;
    logic pulse_clr;

    buf_idx_t    wr_idx_q, wr_idx_d;
    buf_idx_t    rd_idx_q, rd_idx_d;
    buf_idx_t    latest_q, latest_d;
    logic        latest_valid_q, latest_valid_d;
    logic [21:0] wr_addr_q, wr_addr_d;
    logic [21:0] wr_max_q, wr_max_d;
    logic [21:0] rd_addr_q, rd_addr_d;
    logic [21:0] rd_max_q, rd_max_d;

    // FSM state register
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q <= WAIT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: run only while the SDRAM reports initialised
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_INIT: if (sdram_init_done)  state_d = RUN;
            RUN:       if (!sdram_init_done) state_d = WAIT_INIT;
            default:   state_d = WAIT_INIT;
        endcase
    end

    // FSM outputs: starts are honoured only in RUN with init still high
    always_comb begin
        run_en    = (state_q == RUN) && sdram_init_done;
        wr_accept = run_en && wr_frame_start;
        rd_accept = run_en && rd_frame_start;
        pulse_clr = !run_en;
    end

    // Index and address update; read side resolves first so the write side
    // can pick the region that is neither the new read nor the old write
    always_comb begin
        rd_idx_d       = rd_idx_q;
        wr_idx_d       = wr_idx_q;
        latest_d       = latest_q;
        latest_valid_d = latest_valid_q;
        rd_addr_d      = rd_addr_q;
        rd_max_d       = rd_max_q;
        wr_addr_d      = wr_addr_q;
        wr_max_d       = wr_max_q;

        if (rd_accept) begin
            if (latest_valid_q && (latest_q != rd_idx_q)) begin
                rd_idx_d = latest_q;
            end
            rd_addr_d = buf_base(BASE_ADDR, FRAME_SIZE, rd_idx_d);
            rd_max_d  = rd_addr_d + FRAME_SIZE;
        end

        if (wr_accept) begin
            if (frame_write_done) begin
                latest_d       = wr_idx_q;
                latest_valid_d = 1'b1;
                wr_idx_d       = third_buf(rd_idx_d, wr_idx_q);
            end
            wr_addr_d = buf_base(BASE_ADDR, FRAME_SIZE, wr_idx_d);
            wr_max_d  = wr_addr_d + FRAME_SIZE;
        end
    end

    // Scheduler registers
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            wr_idx_q       <= 2'd0;
            rd_idx_q       <= 2'd2;
            latest_q       <= 2'd1;
            latest_valid_q <= 1'b0;
            wr_addr_q      <= BASE_ADDR;
            wr_max_q       <= BASE_ADDR + FRAME_SIZE;
            rd_addr_q      <= buf_base(BASE_ADDR, FRAME_SIZE, 2'd2);
            rd_max_q       <= buf_base(BASE_ADDR, FRAME_SIZE, 2'd2) + FRAME_SIZE;
        end else begin
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            latest_q       <= latest_d;
            latest_valid_q <= latest_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_max_q       <= wr_max_d;
            rd_addr_q      <= rd_addr_d;
            rd_max_q       <= rd_max_d;
        end
    end

    frame_load_pulse #(.LOAD_CYCLES(LOAD_CYCLES)) u_wr_pulse (
        .clk_i   (clk_ref),
        .rst_i   (rst),
        .clr_i   (pulse_clr),
        .start_i (wr_accept),
        .load_o  (wr_load)
    );

    frame_load_pulse #(.LOAD_CYCLES(LOAD_CYCLES)) u_rd_pulse (
        .clk_i   (clk_ref),
        .rst_i   (rst),
        .clr_i   (pulse_clr),
        .start_i (rd_accept),
        .load_o  (rd_load)
    );

`ifdef SDRAM_FRAME_SCHED_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] repeat_cnt_q;

    // Saturating counters of discarded writes and repeated reads
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            drop_cnt_q   <= 16'd0;
            repeat_cnt_q <= 16'd0;
        end else begin
            if (wr_accept && !frame_write_done && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (rd_accept && (rd_idx_d == rd_idx_q) && (repeat_cnt_q != 16'hFFFF)) begin
                repeat_cnt_q <= repeat_cnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign repeat_cnt = repeat_cnt_q;
`endif

    assign wr_idx       = wr_idx_q;
    assign rd_idx       = rd_idx_q;
    assign latest_valid = latest_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_max_addr  = wr_max_q;
    assign rd_addr      = rd_addr_q;
    assign rd_max_addr  = rd_max_q;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed bench for sdram_frame_sched (default parameters: frame regions at
// 0, 307200 and 614400, LOAD_CYCLES=4). Inputs change and outputs are
// sampled on the falling edge of clk_ref.
module tb_sdram_frame_sched;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        frame_write_done = 1'b0;
    logic        wr_load;
    logic [21:0] wr_addr;
    logic [21:0] wr_max_addr;
    logic        rd_load;
    logic [21:0] rd_addr;
    logic [21:0] rd_max_addr;
    logic [1:0]  wr_idx;
    logic [1:0]  rd_idx;
    logic        latest_valid;
`ifdef SDRAM_FRAME_SCHED_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] repeat_cnt;
`endif

    int checks = 0;
    int failures = 0;

    sdram_frame_sched dut (
        .clk_ref          (clk_ref),
        .rst              (rst),
        .sdram_init_done  (sdram_init_done),
        .wr_frame_start   (wr_frame_start),
        .rd_frame_start   (rd_frame_start),
        .frame_write_done (frame_write_done),
        .wr_load          (wr_load),
        .wr_addr          (wr_addr),
        .wr_max_addr      (wr_max_addr),
        .rd_load          (rd_load),
        .rd_addr          (rd_addr),
        .rd_max_addr      (rd_max_addr),
        .wr_idx           (wr_idx),
        .rd_idx           (rd_idx),
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        .drop_cnt         (drop_cnt),
        .repeat_cnt       (repeat_cnt),
`endif
        .latest_valid     (latest_valid)
    );

    // clock
    always #5 clk_ref = ~clk_ref;

    // Driver: one-cycle start pulse(s); called at a falling edge, returns at
    // the next falling edge, where the first strobe cycle is visible.
    task automatic pulse(input logic do_wr, input logic do_rd);
        wr_frame_start = do_wr;
        rd_frame_start = do_rd;
        @(negedge clk_ref);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    // Count strobe-high cycles over the next 10 samples, starting now
    task automatic measure(output int wr_n, output int rd_n);
        wr_n = 0;
        rd_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_load) wr_n++;
            if (rd_load) rd_n++;
            @(negedge clk_ref);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_ref);
        rst = 1'b0;
        @(negedge clk_ref);
        checks++; if (wr_idx !== 2'd0) begin failures++; $display("FAIL rst_wr_idx got=%0d exp=0", wr_idx); end
        checks++; if (rd_idx !== 2'd2) begin failures++; $display("FAIL rst_rd_idx got=%0d exp=2", rd_idx); end
        checks++; if (latest_valid !== 1'b0) begin failures++; $display("FAIL rst_latest_valid got=%0b exp=0", latest_valid); end
        checks++; if (wr_load !== 1'b0 || rd_load !== 1'b0) begin failures++; $display("FAIL rst_loads got=%0b%0b exp=00", wr_load, rd_load); end
        checks++; if (wr_addr !== 22'd0 || wr_max_addr !== 22'd307200) begin failures++; $display("FAIL rst_wr_addr got=%0d/%0d exp=0/307200", wr_addr, wr_max_addr); end
        checks++; if (rd_addr !== 22'd614400 || rd_max_addr !== 22'd921600) begin failures++; $display("FAIL rst_rd_addr got=%0d/%0d exp=614400/921600", rd_addr, rd_max_addr); end
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        checks++; if (drop_cnt !== 16'd0 || repeat_cnt !== 16'd0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", drop_cnt, repeat_cnt); end
`endif
    endtask

    task automatic test_before_init();
        int wn, rn;
        frame_write_done = 1'b1;
        pulse(1'b1, 1'b1);
        measure(wn, rn);
        checks++; if (wn != 0 || rn != 0) begin failures++; $display("FAIL preinit_loads got=%0d/%0d exp=0/0", wn, rn); end
        checks++; if (wr_idx !== 2'd0 || rd_idx !== 2'd2) begin failures++; $display("FAIL preinit_idx got=%0d/%0d exp=0/2", wr_idx, rd_idx); end
        checks++; if (latest_valid !== 1'b0) begin failures++; $display("FAIL preinit_latest_valid got=%0b exp=0", latest_valid); end
    endtask

    task automatic test_read_no_frame();
        int wn, rn;
        sdram_init_done = 1'b1;
        repeat (2) @(negedge clk_ref);
        pulse(1'b0, 1'b1);
        checks++; if (rd_idx !== 2'd2) begin failures++; $display("FAIL rd0_idx got=%0d exp=2", rd_idx); end
        checks++; if (rd_addr !== 22'd614400 || rd_max_addr !== 22'd921600) begin failures++; $display("FAIL rd0_addr got=%0d/%0d exp=614400/921600", rd_addr, rd_max_addr); end
        measure(wn, rn);
        checks++; if (rn != 4 || wn != 0) begin failures++; $display("FAIL rd0_load_width got=%0d/%0d exp=0/4", wn, rn); end
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        checks++; if (repeat_cnt !== 16'd1) begin failures++; $display("FAIL rd0_repeat got=%0d exp=1", repeat_cnt); end
`endif
    endtask

    task automatic test_write_complete();
        int wn, rn;
        frame_write_done = 1'b1;
        pulse(1'b1, 1'b0);
        checks++; if (wr_idx !== 2'd1) begin failures++; $display("FAIL wr1_idx got=%0d exp=1", wr_idx); end
        checks++; if (latest_valid !== 1'b1) begin failures++; $display("FAIL wr1_latest_valid got=%0b exp=1", latest_valid); end
        checks++; if (wr_addr !== 22'd307200 || wr_max_addr !== 22'd614400) begin failures++; $display("FAIL wr1_addr got=%0d/%0d exp=307200/614400", wr_addr, wr_max_addr); end
        checks++; if (rd_idx !== 2'd2) begin failures++; $display("FAIL wr1_rd_idx got=%0d exp=2", rd_idx); end
        measure(wn, rn);
        checks++; if (wn != 4 || rn != 0) begin failures++; $display("FAIL wr1_load_width got=%0d/%0d exp=4/0", wn, rn); end
    endtask

    task automatic test_read_promote();
        int wn, rn;
        pulse(1'b0, 1'b1);
        checks++; if (rd_idx !== 2'd0) begin failures++; $display("FAIL rd1_idx got=%0d exp=0", rd_idx); end
        checks++; if (rd_addr !== 22'd0 || rd_max_addr !== 22'd307200) begin failures++; $display("FAIL rd1_addr got=%0d/%0d exp=0/307200", rd_addr, rd_max_addr); end
        measure(wn, rn);
        checks++; if (rn != 4) begin failures++; $display("FAIL rd1_load_width got=%0d exp=4", rn); end
        pulse(1'b0, 1'b1);
        checks++; if (rd_idx !== 2'd0 || rd_addr !== 22'd0) begin failures++; $display("FAIL rd2_repeat_idx got=%0d/%0d exp=0/0", rd_idx, rd_addr); end
        measure(wn, rn);
        checks++; if (rn != 4) begin failures++; $display("FAIL rd2_load_width got=%0d exp=4", rn); end
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        checks++; if (repeat_cnt !== 16'd2) begin failures++; $display("FAIL rd2_repeat got=%0d exp=2", repeat_cnt); end
`endif
    endtask

    task automatic test_drop();
        int wn, rn;
        frame_write_done = 1'b0;
        pulse(1'b1, 1'b0);
        checks++; if (wr_idx !== 2'd1 || wr_addr !== 22'd307200) begin failures++; $display("FAIL drop_wr got=%0d/%0d exp=1/307200", wr_idx, wr_addr); end
        measure(wn, rn);
        checks++; if (wn != 4) begin failures++; $display("FAIL drop_load_width got=%0d exp=4", wn); end
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
        // latest must still be 0, so the display keeps buffer 0
        pulse(1'b0, 1'b1);
        checks++; if (rd_idx !== 2'd0) begin failures++; $display("FAIL drop_latest_kept got=%0d exp=0", rd_idx); end
        measure(wn, rn);
    endtask

    task automatic test_back_to_back();
        int wn, rn;
        frame_write_done = 1'b1;
        pulse(1'b1, 1'b0);
        checks++; if (wr_idx !== 2'd2 || wr_addr !== 22'd614400 || wr_max_addr !== 22'd921600) begin failures++; $display("FAIL b2b_wr2 got=%0d/%0d/%0d exp=2/614400/921600", wr_idx, wr_addr, wr_max_addr); end
        measure(wn, rn);
        pulse(1'b1, 1'b0);
        checks++; if (wr_idx !== 2'd1 || wr_addr !== 22'd307200) begin failures++; $display("FAIL b2b_wr1 got=%0d/%0d exp=1/307200", wr_idx, wr_addr); end
        measure(wn, rn);
        checks++; if (wn != 4) begin failures++; $display("FAIL b2b_load_width got=%0d exp=4", wn); end
    endtask

    task automatic test_simultaneous();
        int wn, rn;
        // state here: wr=1, rd=0, latest=2
        frame_write_done = 1'b1;
        pulse(1'b1, 1'b1);
        checks++; if (rd_idx !== 2'd2 || rd_addr !== 22'd614400) begin failures++; $display("FAIL sim_rd got=%0d/%0d exp=2/614400", rd_idx, rd_addr); end
        checks++; if (wr_idx !== 2'd0 || wr_addr !== 22'd0 || wr_max_addr !== 22'd307200) begin failures++; $display("FAIL sim_wr got=%0d/%0d/%0d exp=0/0/307200", wr_idx, wr_addr, wr_max_addr); end
        checks++; if (wr_idx === rd_idx) begin failures++; $display("FAIL sim_invariant got=%0d/%0d exp=distinct", wr_idx, rd_idx); end
        measure(wn, rn);
        checks++; if (wn != 4 || rn != 4) begin failures++; $display("FAIL sim_load_width got=%0d/%0d exp=4/4", wn, rn); end
        // latest became 1
        pulse(1'b0, 1'b1);
        checks++; if (rd_idx !== 2'd1 || rd_addr !== 22'd307200 || rd_max_addr !== 22'd614400) begin failures++; $display("FAIL sim_latest got=%0d/%0d/%0d exp=1/307200/614400", rd_idx, rd_addr, rd_max_addr); end
        measure(wn, rn);
    endtask

    task automatic test_restart();
        int total, rises;
        logic prev;
        frame_write_done = 1'b0;
        pulse(1'b1, 1'b0);
        total = 0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (wr_load) total++;
            if (wr_load && !prev) rises++;
            prev = wr_load;
            if (i == 1) pulse(1'b1, 1'b0);
            else @(negedge clk_ref);
        end
        checks++; if (total != 6 || rises != 1) begin failures++; $display("FAIL restart_strobe got=%0d cycles/%0d rises exp=6/1", total, rises); end
        checks++; if (wr_idx !== 2'd0) begin failures++; $display("FAIL restart_wr_idx got=%0d exp=0", wr_idx); end
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        checks++; if (drop_cnt !== 16'd3) begin failures++; $display("FAIL restart_drop got=%0d exp=3", drop_cnt); end
`endif
    endtask

    task automatic test_init_fall();
        int wn, rn;
        sdram_init_done = 1'b0;
        repeat (2) @(negedge clk_ref);
        frame_write_done = 1'b1;
        pulse(1'b1, 1'b1);
        measure(wn, rn);
        checks++; if (wn != 0 || rn != 0) begin failures++; $display("FAIL initfall_loads got=%0d/%0d exp=0/0", wn, rn); end
        checks++; if (wr_idx !== 2'd0 || rd_idx !== 2'd1) begin failures++; $display("FAIL initfall_idx got=%0d/%0d exp=0/1", wr_idx, rd_idx); end
        sdram_init_done = 1'b1;
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_reset_mid_pulse();
        frame_write_done = 1'b1;
        pulse(1'b1, 1'b0);
        // wr=0, rd=1 -> wr becomes 2
        checks++; if (wr_load !== 1'b1 || wr_idx !== 2'd2) begin failures++; $display("FAIL midrst_pre got=%0b/%0d exp=1/2", wr_load, wr_idx); end
        rst = 1'b1;
        @(negedge clk_ref);
        checks++; if (wr_load !== 1'b0) begin failures++; $display("FAIL midrst_wr_load got=%0b exp=0", wr_load); end
        checks++; if (wr_idx !== 2'd0 || rd_idx !== 2'd2 || latest_valid !== 1'b0) begin failures++; $display("FAIL midrst_idx got=%0d/%0d/%0b exp=0/2/0", wr_idx, rd_idx, latest_valid); end
        checks++; if (wr_addr !== 22'd0 || rd_addr !== 22'd614400 || rd_max_addr !== 22'd921600) begin failures++; $display("FAIL midrst_addr got=%0d/%0d/%0d exp=0/614400/921600", wr_addr, rd_addr, rd_max_addr); end
`ifdef SDRAM_FRAME_SCHED_STATS_EN
        checks++; if (drop_cnt !== 16'd0 || repeat_cnt !== 16'd0) begin failures++; $display("FAIL midrst_stats got=%0d/%0d exp=0/0", drop_cnt, repeat_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk_ref);
    endtask

    initial begin
        @(negedge clk_ref);
        test_reset();
        test_before_init();
        test_read_no_frame();
        test_write_complete();
        test_read_promote();
        test_drop();
        test_back_to_back();
        test_simultaneous();
        test_restart();
        test_init_fall();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
